vga_rx_timing: RTL and testbench
================================

VGA_RX_TIMING -- requirements
Module: vga_rx_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800: pixel clocks per line.
REQ-002 SHALL have parameter H_SYNC, default 96: hsync low width, clocks.
REQ-003 SHALL have parameter H_DATA_STA, default 144; H_DATA, default 640: first active column (after hsync fall), active width.
REQ-004 SHALL have parameters V_TOTAL 525, V_SYNC 2, V_DATA_STA 35, V_DATA 480: same meanings, in lines.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2: consecutive matching frames required for lock.
REQ-006 Ports: clk in 1 pixel clock, sole clock; rst in 1 synchronous active-high reset.
REQ-007 Ports: hsync_in in 1, vsync_in in 1 (both active-low); rgb_in in 16 RGB565 {r[15:11],g[10:5],b[4:0]}.
REQ-008 Ports: pixel_x out 12, pixel_y out 12 active-area coordinates; pixel_data out 16; pixel_valid out 1.
REQ-009 Ports: frame_start out 1 pulse; locked out 1; lock_lost out 1 pulse; meas_h_total out 12; meas_v_total out 12.

Function
REQ-010 SHALL register hsync_in, vsync_in, rgb_in once; falling edge = previous sample 1, current sample 0.
REQ-011 SHALL keep h_cnt: 0 on hsync-fall cycle, else +1, saturating at 4095.
REQ-012 SHALL keep v_cnt: +1 per hsync fall, 0 on the hsync fall of the line in which vsync fell, saturating at 4095.
REQ-013 SHALL on each hsync fall load meas_h_total with (h_cnt+1) and record hsync low width; on vsync fall load meas_v_total with (v_cnt+1).
REQ-014 Line match: period == H_TOTAL and low width == H_SYNC; frame match: all lines matched, line count == V_TOTAL, vsync low width == V_SYNC lines.
REQ-015 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-016 SEARCH -> MEASURE on vsync fall; good-frame counter cleared.
REQ-017 MEASURE, at vsync fall: matched frame -> counter +1, reaching LOCK_FRAMES -> LOCKED; unmatched -> counter 0, stay MEASURE.
REQ-018 LOCKED -> SEARCH on any unmatched line or frame, lock_lost high for exactly one clock.
REQ-019 Watchdog: no hsync fall for 2*H_TOTAL clocks -> SEARCH from any state; lock_lost pulses if leaving LOCKED.
REQ-020 locked SHALL be 1 iff state is LOCKED.
REQ-021 pixel_valid SHALL be 1 only when LOCKED and H_DATA_STA <= h_cnt < H_DATA_STA+H_DATA and V_DATA_STA <= v_cnt < V_DATA_STA+V_DATA.
REQ-022 pixel_x = h_cnt-H_DATA_STA, pixel_y = v_cnt-V_DATA_STA when valid; both 0 otherwise.
REQ-023 Latency: rgb_in sampled at clock edge N appears on pixel_data at edge N+2 with matching pixel_valid/x/y; pixel_data 0 when not valid.
REQ-024 frame_start SHALL pulse one clock with first valid pixel (x=0,y=0) of each locked frame.
REQ-025 Simultaneous hsync and vsync fall SHALL be handled in one cycle: v_cnt 0, h_cnt 0, frame evaluated.
REQ-026 Glitch of hsync low shorter than H_SYNC SHALL count as line mismatch (drops lock), not be filtered.

Reset
REQ-027 On rst all outputs 0, counters 0, sampled syncs 1 (idle), FSM SEARCH; rst mid-frame SHALL abort lock and require LOCK_FRAMES new frames after the first vsync fall.

Structure
REQ-028 Timing constants (640x480@60 totals, sync widths, data starts) SHALL live in the shared vga_para package used by the VGA transmitter; parameters default from it.
REQ-029 One sub-module vga_sync_edge SHALL do input registering, edge detection and low-width measurement, instantiated for hsync (unit clocks) and vsync (unit lines).

Verification
REQ-030 Drive 3 nominal 800x525 frames from reset -> locked rises at vsync fall ending frame 2 (first full frame after SEARCH is frame 1); meas_h_total=800, meas_v_total=525.
REQ-031 Locked, rgb_in = {pixel_y[4:0],pixel_x[5:0],5'h0} pattern -> every valid output matches, 640x480 valid pixels per frame, one frame_start per frame.
REQ-032 Locked, one line of 799 clocks -> lock_lost single pulse, locked=0, pixel_valid=0 until relock two frames later.
REQ-033 Locked, hsync held high 1600 clocks -> watchdog to SEARCH, lock_lost pulse, locked=0.
REQ-034 rst asserted at line 200 of locked frame -> all outputs 0 next clock; relock requires 2 matching frames after next vsync fall.
REQ-035 Frame with V_TOTAL 526 in MEASURE -> good counter cleared, no lock that frame, meas_v_total=526.

Source files
------------

// File: rtl/vga_para.sv
// Shared VGA timing constants (640x480@60) and lock-FSM state type, used by
// both the VGA transmitter and the receive-side timing recovery.
package vga_para;

  localparam int VGA_H_TOTAL    = 800;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_DATA_STA = 144;
  localparam int VGA_H_DATA     = 640;
  localparam int VGA_V_TOTAL    = 525;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_DATA_STA = 35;
  localparam int VGA_V_DATA     = 480;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input, flags its falling edge and measures
// the width of each low pulse in units of unit_i (clocks or lines).
module vga_sync_edge
  import vga_para::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_i,
  input  logic        unit_i,
  output logic        fall_o,
  output logic [11:0] width_o
);

  logic        s_q, prev_q;
  logic [11:0] low_cnt_q, width_q;
  logic        rise;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Sample the sync line and keep the previous sample; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s_q    <= sync_i;
      prev_q <= s_q;
    end
  end

  assign fall_o = prev_q & ~s_q;
  assign rise   = ~prev_q & s_q;

  // Count units while low (the falling sample counts as the first unit);
  // the completed width is published on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt_q <= '0;
      width_q   <= '0;
    end else begin
      if (fall_o)              low_cnt_q <= 12'd1;
      else if (!s_q && unit_i) low_cnt_q <= sat_inc(low_cnt_q);
      if (rise)                width_q   <= low_cnt_q;
    end
  end

  assign width_o = width_q;

endmodule

// File: rtl/vga_rx_timing.sv
// VGA receive timing recovery: measures line/frame geometry from incoming
// syncs, locks after LOCK_FRAMES matching frames and emits active pixels
// with coordinates two clocks after sampling.
module vga_rx_timing
  import vga_para::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_DATA_STA  = VGA_H_DATA_STA,
  parameter int H_DATA      = VGA_H_DATA,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_DATA_STA  = VGA_V_DATA_STA,
  parameter int V_DATA      = VGA_V_DATA,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [15:0] rgb_in,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_lost,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_v_total
);

  localparam int WD_LIM = 2 * H_TOTAL - 1;
  localparam int WD_W   = $clog2(2 * H_TOTAL + 1);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic        h_fall, v_fall;
  logic [11:0] h_width, v_width;

  vga_sync_edge u_hsync (
    .clk(clk), .rst(rst), .sync_i(hsync_in), .unit_i(1'b1),
    .fall_o(h_fall), .width_o(h_width)
  );

  vga_sync_edge u_vsync (
    .clk(clk), .rst(rst), .sync_i(vsync_in), .unit_i(h_fall),
    .fall_o(v_fall), .width_o(v_width)
  );

  lock_state_e     state_q, state_d;
  logic [7:0]      good_q, good_d;
  logic            lost_q, lost_d;
  logic [11:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0]     meas_h_q, meas_h_d, meas_v_q, meas_v_d;
  logic            vpend_q, vpend_d, frame_ok_q, frame_ok_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0]     rgb_p0_q, rgb_p1_q;
  logic [11:0]     pix_x_q, pix_y_q;
  logic [15:0]     pix_d_q;
  logic            pix_vld_q, fs_q;
  logic            line_ok, frame_match, timeout, vld_c;

  // h_cnt still holds the last column of the ending line, so period = h_cnt+1.
  assign line_ok     = (sat_inc(h_cnt_q) == 12'(H_TOTAL)) && (h_width == 12'(H_SYNC));
  // The line closed by a coincident hsync fall belongs to the ending frame.
  assign frame_match = frame_ok_q && (!h_fall || line_ok)
                    && (sat_inc(v_cnt_q) == 12'(V_TOTAL)) && (v_width == 12'(V_SYNC));
  assign timeout     = (wd_q == WD_W'(WD_LIM)) && !h_fall;

  // Position counters, measurements, watchdog and per-frame match tracking.
  always_comb begin
    h_cnt_d    = h_fall ? '0 : sat_inc(h_cnt_q);
    v_cnt_d    = v_cnt_q;
    vpend_d    = vpend_q | v_fall;
    if (h_fall) begin
      v_cnt_d = (vpend_q || v_fall) ? '0 : sat_inc(v_cnt_q);
      vpend_d = 1'b0;
    end
    meas_h_d   = h_fall ? sat_inc(h_cnt_q) : meas_h_q;
    meas_v_d   = v_fall ? sat_inc(v_cnt_q) : meas_v_q;
    wd_d       = h_fall ? '0 : ((wd_q == WD_W'(WD_LIM)) ? wd_q : wd_q + WD_W'(1));
    frame_ok_d = frame_ok_q;
    if (v_fall)      frame_ok_d = 1'b1;
    else if (h_fall) frame_ok_d = frame_ok_q & line_ok;
  end

  // Register counters and measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      vpend_q    <= 1'b0;
      meas_h_q   <= '0;
      meas_v_q   <= '0;
      wd_q       <= '0;
      frame_ok_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      vpend_q    <= vpend_d;
      meas_h_q   <= meas_h_d;
      meas_v_q   <= meas_v_d;
      wd_q       <= wd_d;
      frame_ok_q <= frame_ok_d;
    end
  end

  // Lock FSM next state; the watchdog overrides every state.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    lost_d  = 1'b0;
    if (timeout) begin
      state_d = ST_SEARCH;
      lost_d  = (state_q == ST_LOCKED);
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (v_fall) begin
            state_d = ST_MEASURE;
            good_d  = '0;
          end
        end
        ST_MEASURE: begin
          if (v_fall) begin
            if (frame_match) begin
              good_d = good_q + 8'd1;
              if (good_q + 8'd1 >= 8'(LOCK_FRAMES)) state_d = ST_LOCKED;
            end else begin
              good_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if ((h_fall && !line_ok) || (v_fall && !frame_match)) begin
            state_d = ST_SEARCH;
            lost_d  = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEARCH;
      good_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lost_q  <= lost_d;
    end
  end

  // h_cnt_q/v_cnt_q describe the sample now held in rgb_p1_q.
  assign vld_c = (state_q == ST_LOCKED)
              && (h_cnt_q >= 12'(H_DATA_STA)) && (h_cnt_q < 12'(H_DATA_STA + H_DATA))
              && (v_cnt_q >= 12'(V_DATA_STA)) && (v_cnt_q < 12'(V_DATA_STA + V_DATA));

  // Pixel pipeline: input sample, position-aligned sample, output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p0_q  <= '0;
      rgb_p1_q  <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      pix_d_q   <= '0;
      pix_vld_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      rgb_p0_q  <= rgb_in;
      rgb_p1_q  <= rgb_p0_q;
      pix_vld_q <= vld_c;
      pix_x_q   <= vld_c ? h_cnt_q - 12'(H_DATA_STA) : '0;
      pix_y_q   <= vld_c ? v_cnt_q - 12'(V_DATA_STA) : '0;
      pix_d_q   <= vld_c ? rgb_p1_q : '0;
      fs_q      <= vld_c && (h_cnt_q == 12'(H_DATA_STA)) && (v_cnt_q == 12'(V_DATA_STA));
    end
  end

  assign pixel_x      = pix_x_q;
  assign pixel_y      = pix_y_q;
  assign pixel_data   = pix_d_q;
  assign pixel_valid  = pix_vld_q;
  assign frame_start  = fs_q;
  assign locked       = (state_q == ST_LOCKED);
  assign lock_lost    = lost_q;
  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;

endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing with a reduced raster (40x20 totals) so each
// frame is 800 clocks. Pixels expected to be valid are queued as they are
// driven and compared as the DUT emits them.
module tb_vga_rx_timing;

  localparam int HT = 40, HS = 6, HDS = 10, HD = 24;
  localparam int VT = 20, VS = 2, VDS = 4, VD = 12;

  logic        clk, rst, hsync_in, vsync_in;
  logic [15:0] rgb_in;
  logic [11:0] pixel_x, pixel_y, meas_h_total, meas_v_total;
  logic [15:0] pixel_data;
  logic        pixel_valid, frame_start, locked, lock_lost;

  vga_rx_timing #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_DATA_STA(HDS), .H_DATA(HD),
    .V_TOTAL(VT), .V_SYNC(VS), .V_DATA_STA(VDS), .V_DATA(VD), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
    .lock_lost(lock_lost), .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] d;
    logic        fs;
  } px_t;

  px_t sb[$];
  int  checks = 0, errors = 0;
  int  vcnt = 0, fscnt = 0, lost_cnt = 0;
  logic lost_prev = 1'b0;
  int  v0, f0, l0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero();
    check("rst_valid", 32'(pixel_valid), 0);
    check("rst_x", 32'(pixel_x), 0);
    check("rst_y", 32'(pixel_y), 0);
    check("rst_data", 32'(pixel_data), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_lost", 32'(lock_lost), 0);
    check("rst_meas_h", 32'(meas_h_total), 0);
    check("rst_meas_v", 32'(meas_v_total), 0);
  endtask

  // One frame starting with coincident hsync/vsync falls. Pixels of lines
  // below exp_lines are queued. short_line is one clock short, hold_line is
  // replaced by a long hsync-high stretch that ends the frame, rst_line gets
  // a one-clock reset late in the line. lk_chk/mv_chk (-1 = skip) are checked
  // a few clocks after the frame's vsync fall.
  task automatic drive_frame(input int nlines, input int short_line, input int exp_lines,
                             input int lk_chk, input int mv_chk, input int hold_line,
                             input int rst_line);
    int   len;
    logic rp;
    logic [11:0] px, py;
    px_t  e;
    rp = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      if (l == hold_line) begin
        for (int k = 0; k < 2 * HT + 8; k++) begin
          @(negedge clk);
          hsync_in = 1'b1;
          vsync_in = 1'b1;
          rgb_in   = 16'($urandom);
        end
        return;
      end
      len = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (rp) begin
          rst = 1'b0;
          rp  = 1'b0;
          check_zero();
        end
        if (l == 0 && c == 4 && lk_chk >= 0) check("locked_after_vfall", 32'(locked), 32'(lk_chk));
        if (l == 0 && c == 4 && mv_chk >= 0) begin
          check("meas_v_total", 32'(meas_v_total), 32'(mv_chk));
          check("meas_h_total", 32'(meas_h_total), 32'(HT));
        end
        hsync_in = (c < HS) ? 1'b0 : 1'b1;
        vsync_in = (l < VS) ? 1'b0 : 1'b1;
        if (c >= HDS && c < HDS + HD && l >= VDS && l < VDS + VD) begin
          px     = 12'(c - HDS);
          py     = 12'(l - VDS);
          rgb_in = {py[4:0], px[5:0], 5'h00};
          if (l < exp_lines) begin
            e.x  = px;
            e.y  = py;
            e.d  = rgb_in;
            e.fs = (px == 12'd0) && (py == 12'd0);
            sb.push_back(e);
          end
        end else begin
          rgb_in = 16'($urandom);
        end
        if (l == rst_line && c == 38) begin
          rst = 1'b1;
          rp  = 1'b1;
        end
      end
    end
  endtask

  // Output monitor: compares emitted pixels against the queue, checks idle
  // outputs are zero and that lock_lost never lasts more than one clock.
  always @(negedge clk) begin
    px_t e;
    if (pixel_valid) begin
      vcnt++;
      if (frame_start) fscnt++;
      check("pixel_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pixel_x", 32'(pixel_x), 32'(e.x));
        check("pixel_y", 32'(pixel_y), 32'(e.y));
        check("pixel_data", 32'(pixel_data), 32'(e.d));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end else begin
      check("idle_xy", {8'h00, pixel_x, pixel_y}, 0);
      check("idle_data_fs", {15'h0000, pixel_data, frame_start}, 0);
    end
    if (lock_lost) begin
      lost_cnt++;
      check("lock_lost_width", 32'(lost_prev), 0);
    end
    lost_prev = lock_lost;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero();
    repeat (4) @(negedge clk);

    // Acquire: lock at the vsync fall ending frame 2, then full frames.
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    v0 = vcnt; f0 = fscnt;
    drive_frame(VT, -1, VT, 1, VT, -1, -1);
    check("valid_per_frame", 32'(vcnt - v0), 32'(HD * VD));
    check("fs_per_frame", 32'(fscnt - f0), 1);
    v0 = vcnt; f0 = fscnt;
    drive_frame(VT, -1, VT, 1, VT, -1, -1);
    check("valid_per_frame2", 32'(vcnt - v0), 32'(HD * VD));
    check("fs_per_frame2", 32'(fscnt - f0), 1);

    // One short line drops lock; relock two frames after the next vsync fall.
    l0 = lost_cnt;
    drive_frame(VT, 8, 9, 1, -1, -1, -1);
    check("short_lost", 32'(lost_cnt - l0), 1);
    check("short_unlocked", 32'(locked), 0);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, VT, 1, VT, -1, -1);

    // Missing hsync: watchdog returns to SEARCH.
    l0 = lost_cnt;
    drive_frame(VT, -1, 8, 1, -1, 8, -1);
    check("wd_lost", 32'(lost_cnt - l0), 1);
    check("wd_unlocked", 32'(locked), 0);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, VT, 1, VT, -1, -1);

    // Reset in the middle of a locked frame.
    drive_frame(VT, -1, 9, 1, -1, -1, 8);
    check("rst_mid_unlocked", 32'(locked), 0);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, VT, 1, VT, -1, -1);

    // A long frame while measuring clears the good-frame count.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("pre_measure_unlocked", 32'(locked), 0);
    drive_frame(VT, -1, 0, 0, -1, -1, -1);
    drive_frame(VT + 1, -1, 0, 0, -1, -1, -1);
    drive_frame(VT, -1, 0, 0, VT + 1, -1, -1);
    drive_frame(VT, -1, 0, 0, VT, -1, -1);
    drive_frame(VT, -1, VT, 1, VT, -1, -1);

    repeat (8) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
